// File: rtl/pc_sequencer.sv
// Program-counter sequencer: IDLE/RUN/HALT control with a 16-entry offset table
// supporting sequential, PC-relative and absolute branch updates.
module pc_sequencer #(
  parameter int PC_width = 10
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cfg_valid,
  input  logic [3:0]          cfg_idx,
  input  logic [PC_width-1:0] cfg_data,
  output logic                cfg_ready,
  input  logic                start,
  input  logic [PC_width-1:0] start_addr,
  input  logic                advance,
  input  logic                branch,
  input  logic [3:0]          br_idx,
  input  logic                br_abs,
  input  logic                halt_req,
  output logic [PC_width-1:0] pc,
  output logic                running,
  output logic                done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  state_t              state, state_nxt;
  logic [PC_width-1:0] pc_nxt;
  logic                done_nxt;
  logic [PC_width-1:0] offset_tbl [16];

  assign cfg_ready = (state != RUN);
  assign running   = (state == RUN);

  // NOTE: every output of this block gets a default before the case, so no
  // path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    done_nxt  = 1'b0;
    case (state)
      IDLE, HALT: begin
        if (start) begin
          pc_nxt    = start_addr;
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (advance) begin
          if (!branch)
            pc_nxt = pc + PC_width'(1);
          else if (br_abs)
            pc_nxt = offset_tbl[br_idx];
          else
            pc_nxt = pc + offset_tbl[br_idx];  // two's-complement add wraps naturally
        end
        // The PC update above still lands on the halting edge.
        if (halt_req) begin
          state_nxt = HALT;
          done_nxt  = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      pc    <= '0;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
      done  <= done_nxt;
    end
  end

  // NOTE: the table is built from resettable flops rather than a RAM because
  // every entry must read back as 1 immediately after reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 16; i++)
        offset_tbl[i] <= PC_width'(1);
    end else if (cfg_valid && cfg_ready) begin
      offset_tbl[cfg_idx] <= cfg_data;
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios followed by random
// traffic, all compared against a behavioural model of the sequencing rules.
module tb_pc_sequencer;

  localparam int W = 10;
  localparam int M = 1 << W;

  logic         clk = 1'b0;
  logic         reset;
  logic         cfg_valid;
  logic [3:0]   cfg_idx;
  logic [W-1:0] cfg_data;
  logic         cfg_ready;
  logic         start;
  logic [W-1:0] start_addr;
  logic         advance;
  logic         branch;
  logic [3:0]   br_idx;
  logic         br_abs;
  logic         halt_req;
  logic [W-1:0] pc;
  logic         running;
  logic         done;

  always #5 clk = ~clk;

  pc_sequencer #(.PC_width(W)) dut (
    .clk        (clk),
    .reset      (reset),
    .cfg_valid  (cfg_valid),
    .cfg_idx    (cfg_idx),
    .cfg_data   (cfg_data),
    .cfg_ready  (cfg_ready),
    .start      (start),
    .start_addr (start_addr),
    .advance    (advance),
    .branch     (branch),
    .br_idx     (br_idx),
    .br_abs     (br_abs),
    .halt_req   (halt_req),
    .pc         (pc),
    .running    (running),
    .done       (done)
  );

  int checks = 0;
  int errors = 0;

  // Behavioural reference: PC as an integer, running/done as flags, table as ints.
  int m_pc;
  bit m_run;
  bit m_done;
  int m_tbl [16];

  function automatic int wrap(input int v);
    return ((v % M) + M) % M;
  endfunction

  function automatic int as_signed(input int e);
    return (e >= M / 2) ? e - M : e;
  endfunction

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic clear_inputs();
    cfg_valid  = 1'b0;
    cfg_idx    = '0;
    cfg_data   = '0;
    start      = 1'b0;
    start_addr = '0;
    advance    = 1'b0;
    branch     = 1'b0;
    br_idx     = '0;
    br_abs     = 1'b0;
    halt_req   = 1'b0;
  endtask

  task automatic model_reset();
    m_pc   = 0;
    m_run  = 1'b0;
    m_done = 1'b0;
    for (int i = 0; i < 16; i++) m_tbl[i] = 1;
  endtask

  // One rising edge of the intended behaviour, evaluated from the current inputs.
  task automatic model_edge();
    int nxt;
    bit wr;
    nxt    = m_pc;
    wr     = cfg_valid && !m_run;
    m_done = 1'b0;
    if (m_run) begin
      if (advance) begin
        if (!branch)     nxt = m_pc + 1;
        else if (br_abs) nxt = m_tbl[br_idx];
        else             nxt = m_pc + as_signed(m_tbl[br_idx]);
      end
      if (halt_req) begin
        m_run  = 1'b0;
        m_done = 1'b1;
      end
    end else if (start) begin
      nxt   = int'(start_addr);
      m_run = 1'b1;
    end
    m_pc = wrap(nxt);
    if (wr) m_tbl[cfg_idx] = int'(cfg_data);
  endtask

  task automatic check_model(input string tag);
    check({tag, "_pc"},      32'(pc),        m_pc);
    check({tag, "_running"}, 32'(running),   32'(m_run));
    check({tag, "_done"},    32'(done),      32'(m_done));
    check({tag, "_ready"},   32'(cfg_ready), 32'(!m_run));
  endtask

  task automatic tick(input string tag);
    model_edge();
    @(posedge clk);
    #1;
    check_model(tag);
    clear_inputs();
  endtask

  // Asynchronous reset asserted away from the clock edge and checked before any edge.
  task automatic do_reset(input string tag);
    reset = 1'b1;
    #1;
    model_reset();
    check_model(tag);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    clear_inputs();
    reset = 1'b1;
    #2;
    do_reset("rst0");

    // Sequential execution from 8.
    start = 1'b1; start_addr = W'(8);
    tick("seq_start");
    check("seq_pc8", 32'(pc), 8);
    check("seq_running", 32'(running), 1);
    for (int i = 0; i < 3; i++) begin
      advance = 1'b1;
      tick("seq_adv");
      check("seq_pc_inc", 32'(pc), 32'(9 + i));
    end

    // Write table[4] = -40 together with start in IDLE, then relative branch.
    do_reset("rst1");
    cfg_valid = 1'b1; cfg_idx = 4'd4; cfg_data = W'(10'h3D8);
    start = 1'b1; start_addr = W'(50);
    tick("cfg_and_start");
    check("rel_start_pc50", 32'(pc), 50);
    advance = 1'b1; branch = 1'b1; br_idx = 4'd4;
    tick("rel_neg");
    check("rel_neg_pc10", 32'(pc), 10);
    halt_req = 1'b1;
    tick("halt1");
    check("halt1_done", 32'(done), 1);
    cfg_valid = 1'b1; cfg_idx = 4'd15; cfg_data = W'(143);
    tick("cfg15");
    check("halt1_done_once", 32'(done), 0);
    cfg_valid = 1'b1; cfg_idx = 4'd0; cfg_data = W'(41);
    tick("cfg0");

    // Absolute branch, then unconfigured relative entry.
    start = 1'b1; start_addr = W'(20);
    tick("abs_start");
    advance = 1'b1; branch = 1'b1; br_abs = 1'b1; br_idx = 4'd15;
    tick("abs_br");
    check("abs_pc143", 32'(pc), 143);
    advance = 1'b1; branch = 1'b1; br_idx = 4'd3;
    tick("unconf_br");
    check("unconf_pc144", 32'(pc), 144);
    start = 1'b1; start_addr = W'(500);
    tick("start_in_run");
    check("start_ignored_pc", 32'(pc), 144);
    halt_req = 1'b1;
    tick("halt2");
    halt_req = 1'b1;
    tick("halt_outside_run");
    check("halt_outside_done", 32'(done), 0);

    // Wrap-around cases.
    start = 1'b1; start_addr = W'(1023);
    tick("wrap_start");
    advance = 1'b1;
    tick("wrap_inc");
    check("wrap_pc0", 32'(pc), 0);
    halt_req = 1'b1;
    tick("halt3");
    start = 1'b1; start_addr = W'(1000);
    tick("wrap2_start");
    advance = 1'b1; branch = 1'b1; br_idx = 4'd0;
    tick("wrap_rel");
    check("wrap_rel_pc17", 32'(pc), 17);
    halt_req = 1'b1;
    tick("halt4");

    // Write in RUN is dropped; halt together with advance.
    start = 1'b1; start_addr = W'(5);
    tick("drop_start");
    cfg_valid = 1'b1; cfg_idx = 4'd1; cfg_data = W'(99);
    tick("drop_cfg");
    check("drop_ready0", 32'(cfg_ready), 0);
    advance = 1'b1; branch = 1'b1; br_idx = 4'd1;
    tick("drop_br");
    check("drop_pc6", 32'(pc), 6);
    halt_req = 1'b1; advance = 1'b1;
    tick("halt_adv");
    check("halt_adv_pc7", 32'(pc), 7);
    check("halt_adv_done", 32'(done), 1);
    check("halt_adv_ready", 32'(cfg_ready), 1);
    tick("halt_hold");
    check("halt_hold_pc7", 32'(pc), 7);
    check("halt_hold_done0", 32'(done), 0);

    // Asynchronous reset mid-RUN clears state and the table.
    start = 1'b1; start_addr = W'(30);
    tick("arst_start");
    check("arst_pc30", 32'(pc), 30);
    #2;
    do_reset("arst");
    start = 1'b1; start_addr = W'(0);
    tick("post_rst_start");
    advance = 1'b1; branch = 1'b1; br_idx = 4'd4;
    tick("post_rst_rel");
    check("post_rst_tbl4", 32'(pc), 1);
    advance = 1'b1; branch = 1'b1; br_abs = 1'b1; br_idx = 4'd15;
    tick("post_rst_abs");
    check("post_rst_tbl15", 32'(pc), 1);

    // Random traffic against the model.
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 63) == 0) begin
        #2;
        do_reset("rnd_rst");
      end else begin
        start      = ($urandom_range(0, 7) == 0);
        start_addr = W'($urandom);
        advance    = ($urandom_range(0, 1) == 1);
        branch     = ($urandom_range(0, 2) != 0);
        br_idx     = 4'($urandom);
        br_abs     = ($urandom_range(0, 3) == 0);
        halt_req   = ($urandom_range(0, 11) == 0);
        cfg_valid  = ($urandom_range(0, 2) == 0);
        cfg_idx    = 4'($urandom);
        cfg_data   = W'($urandom);
        tick("rnd");
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 The block SHALL have parameter PC_width, default 10, giving the width of the program counter and of every offset-table entry.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL have port cfg_valid, input, 1 bit: an offset-table write request.
REQ-005 The block SHALL have port cfg_idx, input, 4 bits: the table entry to write.
REQ-006 The block SHALL have port cfg_data, input, PC_width bits: the entry value, a two's-complement offset or an absolute target.
REQ-007 The block SHALL have port cfg_ready, output, 1 bit: the table accepts a write this cycle.
REQ-008 The block SHALL have port start, input, 1 bit: a single-cycle pulse that begins execution.
REQ-009 The block SHALL have port start_addr, input, PC_width bits: the initial PC, sampled on start.
REQ-010 The block SHALL have port advance, input, 1 bit: the current instruction has retired, so the PC updates.
REQ-011 The block SHALL have port branch, input, 1 bit: the retiring instruction is a taken branch.
REQ-012 The block SHALL have port br_idx, input, 4 bits: the offset-table pointer for a taken branch.
REQ-013 The block SHALL have port br_abs, input, 1 bit: 1 selects an absolute target; 0 selects PC-relative.
REQ-014 The block SHALL have port halt_req, input, 1 bit: stop execution.
REQ-015 The block SHALL have port pc, output, PC_width bits: the current program counter.
REQ-016 The block SHALL have port running, output, 1 bit: high in the RUN state.
REQ-017 The block SHALL have port done, output, 1 bit: a one-cycle pulse on entry to HALT.

Function
REQ-018 The block SHALL hold a 16 x PC_width offset table; a write is accepted when cfg_valid && cfg_ready, and the new value is visible from the next cycle.
REQ-019 The block SHALL implement FSM states IDLE, RUN and HALT, with cfg_ready = 1 only in IDLE or HALT; a cfg_valid in RUN SHALL be ignored and not queued.
REQ-020 In IDLE or HALT, start SHALL load pc <= start_addr and enter RUN on the next edge; a start in RUN SHALL be ignored.
REQ-021 If start and cfg_valid are both asserted in IDLE, the block SHALL perform both the write and the start in the same edge.
REQ-022 In RUN with advance = 1 and branch = 0, the block SHALL set pc <= pc + 1.
REQ-023 In RUN with advance = 1, branch = 1 and br_abs = 0, the block SHALL set pc <= pc + table[br_idx], treating the entry as two's complement.
REQ-024 In RUN with advance = 1, branch = 1 and br_abs = 1, the block SHALL set pc <= table[br_idx].
REQ-025 All PC arithmetic SHALL be modulo 2^PC_width, with silent wrap and no flag.
REQ-026 With advance = 0, pc SHALL hold; branch and br_idx SHALL be ignored.
REQ-027 halt_req in RUN SHALL enter HALT on the next edge, and pc SHALL freeze at its current value.
REQ-028 If halt_req and advance are asserted together, the block SHALL first apply the PC update for that cycle, then halt.
REQ-029 done SHALL be 1 for exactly the first cycle in HALT, and 0 otherwise.
REQ-030 halt_req outside RUN SHALL be ignored.
REQ-031 The block SHALL have zero-latency visibility: pc is a register output, and an update made at edge N is visible after edge N.

Reset
REQ-032 Asserting reset SHALL immediately force the state to IDLE, pc = 0, running = 0, done = 0 and cfg_ready = 1, independent of clk.
REQ-033 Reset SHALL initialise every table entry to 1, so an unconfigured relative branch behaves as pc + 1.
REQ-034 Reset asserted mid-RUN SHALL abort execution; no pending update SHALL apply after release.
REQ-035 After reset is released, the first edge SHALL operate normally.

Verification
REQ-036 The bench SHALL cover: reset; start with start_addr = 8; three cycles of advance with branch = 0 -> pc = 8, 9, 10, 11; running = 1.
REQ-037 The bench SHALL cover: in IDLE, write table[4] = -40 (0x3D8); start with start_addr = 50; advance with branch = 1, br_idx = 4, br_abs = 0 -> pc = 10.
REQ-038 The bench SHALL cover: write table[15] = 143; at pc = 20, branch with br_abs = 1, br_idx = 15 -> pc = 143; then an unconfigured br_idx = 3, relative -> pc = 144.
REQ-039 The bench SHALL cover: wrap-around at pc = 1023 with advance -> pc = 0; table[0] = 41 relative from pc = 1000 -> pc = 17.
REQ-040 The bench SHALL cover: cfg_valid in RUN writing table[1] = 99, then branch on idx 1 relative from pc = 5 -> pc = 6 (write dropped); halt_req with advance at pc = 6 -> pc = 7, HALT, done pulses once, cfg_ready = 1.
REQ-041 The bench SHALL cover: reset asserted asynchronously mid-RUN at pc = 30 -> pc = 0, state IDLE and table reset to 1 before the next clk edge.
